data_memory_str: RTL and testbench
==================================

// Module: data_memory_str
// PURPOSE
//  Parametrised data memory for the MIPS datapath: byte/half/word loads and stores,
//  configurable depth below a top address, and alignment/range fault detection.
//  Adds a syscall string-read port: an FSM that walks bytes from an address until
//  NUL and streams each character over a valid/ready handshake to the print/syscall unit.
// PARAMETERS
//  TOP_ADDR   32'h7ffffffc  byte address of highest word (stack top), word aligned
//  DEPTH      256           number of 32-bit words; region [TOP_ADDR-4*(DEPTH-1), TOP_ADDR+3]
//  MAX_STR    1024          max characters streamed per string request (NUL excluded)
// PORTS
//  clk         in   1   clock; all state updates on rising edge
//  reset       in   1   synchronous, active-high
//  mem_write   in   1   store enable
//  mem_read    in   1   load enable
//  size        in   2   access size: 00 byte, 01 half, 10 word (11 reserved = fault)
//  load_signed in   1   1 = sign-extend byte/half loads, 0 = zero-extend
//  address     in   32  byte address
//  write_data  in   32  store data (low byte/half used for sub-word stores)
//  read_data   out  32  load data, extended per size/load_signed
//  addr_fault  out  1   misaligned, out of range, or reserved size on active access
//  str_start   in   1   request: stream the NUL-terminated string at str_addr
//  str_addr    in   32  byte address of first character
//  str_busy    out  1   FSM not IDLE
//  str_char    out  8   current character
//  str_valid   out  1   str_char valid
//  str_ready   in   1   consumer accepts str_char
//  str_done    out  1   one-cycle pulse at end of string
//  str_err     out  1   with str_done: ended on fault or MAX_STR, not NUL
// BEHAVIOUR
//  - Little-endian: byte k of a word = bits [8k+7:8k]. Word index = (address-base)>>2.
//  - Loads combinational (same-cycle, single-cycle CPU): read_data valid while mem_read=1;
//    read_data = 0 when mem_read=0 or addr_fault=1.
//  - Stores commit on rising clk when mem_write=1 and addr_fault=0; only addressed
//    bytes change. Faulting store writes nothing.
//  - addr_fault (combinational, only when mem_read|mem_write): half with address[0]=1,
//    word with address[1:0]!=0, size=11, or any touched byte outside the region.
//  - Array contents are NOT cleared by reset; reset clears all outputs and FSM state.
//  - FSM states: IDLE, FETCH, OUT, DONE.
//    IDLE: str_start=1 -> latch ptr=str_addr, cnt=0, go FETCH.
//    FETCH (1 cycle): read byte at ptr via private read port into str_char.
//      ptr out of range -> DONE with err; byte==0 -> DONE, err=0;
//      cnt==MAX_STR -> DONE with err; else OUT.
//    OUT: str_valid=1, str_char stable until str_valid&&str_ready; then ptr+1, cnt+1, FETCH.
//    DONE: str_done=1 for exactly one cycle, str_err valid; then IDLE.
//  - Throughput: one char per 2 cycles with str_ready held high.
//  - str_start while busy is ignored (no queueing).
//  - CPU store and FETCH to same byte same edge: FETCH returns pre-store value.
//  - reset mid-string: next cycle IDLE; str_valid/str_done/str_err/str_busy = 0,
//    str_char = 0, no pulse emitted.
//  - ptr increments 32-bit, no wrap special case (range check catches it).
// STRUCTURE
//  - Package mem_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state enum,
//    byte-lane-mask and extension helper functions.
//  - One sub-module: str_fetch_fsm (state, ptr, cnt, handshake); top holds the
//    array, CPU port, fault logic, and the FSM's byte read port.
// TESTING
//  - sw 0xDEADBEEF @0x7ffffffc; lw -> 0xDEADBEEF; lb @0x7fffffff signed -> 0xFFFFFFDE.
//  - sb 0x41 @0x7ffffff9 over word 0 -> lw @0x7ffffff8 = 0x00004100; lhu @..fa = 0x0000.
//  - lw @0x7ffffffe -> addr_fault=1, read_data=0; sw @0x7ffffffd -> fault, memory unchanged.
//  - "Hi\0" at 0x7ffffff0, str_ready=1 -> str_char 'H','i' each 1 valid cycle, then
//    str_done=1 str_err=0; total 6 cycles after str_start.
//  - Same string, str_ready low 5 cycles -> 'H' held stable, no loss/duplication.
//  - reset asserted while in OUT -> next cycle all str_* outputs 0; new str_start works.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the data memory: access sizes, string FSM states,
// byte-lane masks and load extension.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_OUT   = 2'b10,
        ST_DONE  = 2'b11
    } str_state_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            SZ_BYTE: m = 4'b0001 << lo;
            SZ_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Sub-word store data is replicated so every lane carries the value to write.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        d = 32'h0000_0000;
        case (size)
            SZ_BYTE: d = {4{wd[7:0]}};
            SZ_HALF: d = {2{wd[15:0]}};
            SZ_WORD: d = wd;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lo, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lo, 3'b000} +: 8];
        h = word[{lo[1], 4'b0000} +: 16];
        r = 32'h0000_0000;
        case (size)
            SZ_BYTE: r = sgn ? {{24{b[7]}}, b} : {24'h00_0000, b};
            SZ_HALF: r = sgn ? {{16{h[15]}}, h} : {16'h0000, h};
            SZ_WORD: r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/str_fetch_fsm.sv
// String streaming engine: walks bytes from a start pointer until NUL, fault or length
// limit, presenting each character over a valid/ready handshake.
module str_fetch_fsm
    import mem_pkg::*;
#(
    parameter int MAX_STR = 1024,
    parameter int CW      = $clog2(MAX_STR + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        str_start,
    input  logic [31:0] str_addr,
    input  logic        str_ready,
    input  logic [7:0]  fetch_byte,
    input  logic        fetch_ok,
    output logic [31:0] ptr,
    output logic        str_busy,
    output logic [7:0]  str_char,
    output logic        str_valid,
    output logic        str_done,
    output logic        str_err
);

    str_state_t    state_r, state_next;
    logic [31:0]   ptr_r, ptr_next;
    logic [CW-1:0] cnt_r, cnt_next;
    logic [7:0]    char_r, char_next;
    logic          err_r, err_next;
    logic          valid_r, done_r, busy_r;

    // Next-state logic; err is only raised on the transition into DONE so it lasts one cycle.
    always_comb begin
        state_next = state_r;
        ptr_next   = ptr_r;
        cnt_next   = cnt_r;
        char_next  = char_r;
        err_next   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (str_start) begin
                    ptr_next   = str_addr;
                    cnt_next   = {CW{1'b0}};
                    char_next  = 8'h00;
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (!fetch_ok) begin
                    char_next  = 8'h00;
                    err_next   = 1'b1;
                    state_next = ST_DONE;
                end else if (fetch_byte == 8'h00) begin
                    char_next  = 8'h00;
                    state_next = ST_DONE;
                end else if (cnt_r == CW'(MAX_STR)) begin
                    char_next  = 8'h00;
                    err_next   = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    char_next  = fetch_byte;
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (str_ready) begin
                    ptr_next   = ptr_r + 32'd1;
                    cnt_next   = cnt_r + CW'(1);
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_OUT;
                end
            end
            ST_DONE: begin
                char_next  = 8'h00;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and registered handshake outputs, derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= 32'h0000_0000;
            cnt_r   <= {CW{1'b0}};
            char_r  <= 8'h00;
            err_r   <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next;
            ptr_r   <= ptr_next;
            cnt_r   <= cnt_next;
            char_r  <= char_next;
            err_r   <= err_next;
            valid_r <= (state_next == ST_OUT);
            done_r  <= (state_next == ST_DONE);
            busy_r  <= (state_next != ST_IDLE);
        end
    end

    assign ptr       = ptr_r;
    assign str_busy  = busy_r;
    assign str_char  = char_r;
    assign str_valid = valid_r;
    assign str_done  = done_r;
    assign str_err   = err_r;

endmodule

// File: rtl/data_memory_str.sv
// MIPS data memory with byte/half/word access, alignment/range faults, and a private
// byte read port feeding the string streaming engine.
module data_memory_str
    import mem_pkg::*;
#(
    parameter logic [31:0] TOP_ADDR = 32'h7fff_fffc,
    parameter int          DEPTH    = 256,
    parameter int          MAX_STR  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [1:0]  size,
    input  logic        load_signed,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        addr_fault,
    input  logic        str_start,
    input  logic [31:0] str_addr,
    output logic        str_busy,
    output logic [7:0]  str_char,
    output logic        str_valid,
    input  logic        str_ready,
    output logic        str_done,
    output logic        str_err
);

    localparam int          IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] BASE = TOP_ADDR - 32'(4 * (DEPTH - 1));
    localparam logic [32:0] SPAN = 33'(4 * DEPTH);

    logic [31:0] mem [DEPTH];

    logic [31:0]     cpu_off;
    logic            cpu_in_range;
    logic            cpu_misalign;
    logic [IDXW-1:0] cpu_idx;
    logic            fault_s;
    logic [3:0]      wmask_s;
    logic [31:0]     wdata_s;

    logic [31:0]     str_ptr;
    logic [31:0]     str_off;
    logic            str_ok;
    logic [IDXW-1:0] str_idx;
    logic [31:0]     str_word;
    logic [7:0]      fetch_byte;

    // Region starts word aligned, so aligned accesses with an in-range start stay in range.
    assign cpu_off      = address - BASE;
    assign cpu_in_range = ({1'b0, cpu_off} < SPAN);
    assign cpu_idx      = cpu_off[IDXW+1:2];
    assign wmask_s      = lane_mask(size, address[1:0]);
    assign wdata_s      = store_lanes(size, write_data);

    // Fault detection for the CPU port.
    always_comb begin
        cpu_misalign = 1'b0;
        case (size)
            SZ_BYTE: cpu_misalign = 1'b0;
            SZ_HALF: cpu_misalign = address[0];
            SZ_WORD: cpu_misalign = (address[1:0] != 2'b00);
            default: cpu_misalign = 1'b1;
        endcase
        if (mem_read || mem_write) begin
            fault_s = cpu_misalign || !cpu_in_range;
        end else begin
            fault_s = 1'b0;
        end
    end

    // Combinational load path, zero when idle or faulting.
    always_comb begin
        read_data = 32'h0000_0000;
        if (mem_read && !fault_s) begin
            read_data = load_extend(mem[cpu_idx], size, address[1:0], load_signed);
        end else begin
            read_data = 32'h0000_0000;
        end
    end

    assign addr_fault = fault_s;

    // Byte-lane store; array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_write && !fault_s) begin
            for (int k = 0; k < 4; k++) begin
                if (wmask_s[k]) begin
                    mem[cpu_idx][8*k +: 8] <= wdata_s[8*k +: 8];
                end
            end
        end
    end

    assign str_off    = str_ptr - BASE;
    assign str_ok     = ({1'b0, str_off} < SPAN);
    assign str_idx    = str_off[IDXW+1:2];
    assign str_word   = mem[str_idx];
    assign fetch_byte = str_word[{str_off[1:0], 3'b000} +: 8];

    str_fetch_fsm #(
        .MAX_STR (MAX_STR)
    ) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .str_start  (str_start),
        .str_addr   (str_addr),
        .str_ready  (str_ready),
        .fetch_byte (fetch_byte),
        .fetch_ok   (str_ok),
        .ptr        (str_ptr),
        .str_busy   (str_busy),
        .str_char   (str_char),
        .str_valid  (str_valid),
        .str_done   (str_done),
        .str_err    (str_err)
    );

endmodule

// File: tb/tb_data_memory_str.sv
// Randomized self-checking bench for data_memory_str against a byte-array reference model.
module tb_data_memory_str;

    localparam logic [31:0] TOP     = 32'h7fff_fffc;
    localparam int          DEPTH   = 256;
    localparam int          MAX_STR = 16;
    localparam logic [31:0] BASE    = TOP - 32'(4 * (DEPTH - 1));

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write, mem_read, load_signed;
    logic [1:0]  size;
    logic [31:0] address, write_data, read_data;
    logic        addr_fault;
    logic        str_start, str_busy, str_valid, str_ready, str_done, str_err;
    logic [31:0] str_addr;
    logic [7:0]  str_char;

    int total = 0;
    int bad   = 0;
    logic [7:0] ref_mem [4*DEPTH];

    data_memory_str #(.TOP_ADDR(TOP), .DEPTH(DEPTH), .MAX_STR(MAX_STR)) dut (
        .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read), .size(size),
        .load_signed(load_signed), .address(address), .write_data(write_data),
        .read_data(read_data), .addr_fault(addr_fault), .str_start(str_start),
        .str_addr(str_addr), .str_busy(str_busy), .str_char(str_char), .str_valid(str_valid),
        .str_ready(str_ready), .str_done(str_done), .str_err(str_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit ref_fault(input logic [31:0] a, input logic [1:0] sz);
        longint lo, hi;
        int n;
        if (sz == 2'b11) return 1'b1;
        n = nbytes(sz);
        if ((a % n) != 0) return 1'b1;
        lo = longint'(a);
        hi = lo + n - 1;
        return (lo < longint'(BASE)) || (hi > longint'(TOP) + 3);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input bit sgn);
        logic [31:0] v;
        int n;
        if (ref_fault(a, sz)) return 32'h0;
        n = nbytes(sz);
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a - BASE) + i]) << (8 * i));
        if (sgn && n == 1 && v[7])  v = v | 32'hffff_ff00;
        if (sgn && n == 2 && v[15]) v = v | 32'hffff_0000;
        return v;
    endfunction

    task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        bit f;
        @(negedge clk);
        mem_write = 1'b1; mem_read = 1'b0; address = a; size = sz; write_data = d;
        #1;
        f = ref_fault(a, sz);
        chk("st_fault", 32'(addr_fault), 32'(f));
        chk("st_rdata", read_data, 32'h0);
        @(posedge clk);
        if (!f) for (int i = 0; i < nbytes(sz); i++) ref_mem[int'(a - BASE) + i] = d[8*i +: 8];
        #1 mem_write = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input bit sgn);
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; address = a; size = sz; load_signed = sgn;
        #1;
        chk("ld_fault", 32'(addr_fault), 32'(ref_fault(a, sz)));
        chk("ld_data", read_data, ref_load(a, sz, sgn));
        mem_read = 1'b0;
    endtask

    task automatic load_const(input string tag, input logic [31:0] a, input logic [1:0] sz,
                              input bit sgn, input logic [31:0] exp, input bit exp_f);
        @(negedge clk);
        mem_read = 1'b1; address = a; size = sz; load_signed = sgn;
        #1;
        chk({tag, "_f"}, 32'(addr_fault), 32'(exp_f));
        chk(tag, read_data, exp);
        mem_read = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 3))
            0: return BASE + 32'($urandom_range(0, 4*DEPTH - 1));
            1: return BASE - 32'($urandom_range(1, 8));
            2: return TOP + 32'($urandom_range(0, 11));
            default: return 32'($urandom);
        endcase
    endfunction

    // Streams one string; mode 0 ready high, 1 ready low for 5 cycles, 2 random.
    task automatic run_string(input logic [31:0] a, input int mode, input bit poke,
                              output int cycles, output int vcnt);
        logic [7:0] exp_q [$];
        logic [7:0] got_q [$];
        bit exp_err, got_err, done_seen, pending, r;
        logic [7:0] held;
        int cyc;
        logic [31:0] p;
        exp_err = 1'b0;
        for (int i = 0; ; i++) begin
            p = a + 32'(i);
            if (ref_fault(p, 2'b00)) begin exp_err = 1'b1; break; end
            if (ref_mem[int'(p - BASE)] == 8'h00) break;
            if (i == MAX_STR) begin exp_err = 1'b1; break; end
            exp_q.push_back(ref_mem[int'(p - BASE)]);
        end
        @(negedge clk);
        str_addr = a; str_start = 1'b1; str_ready = 1'b0;
        @(negedge clk);
        str_start = 1'b0;
        cyc = 1; vcnt = 0; done_seen = 1'b0; pending = 1'b0; got_err = 1'b0; held = 8'h00;
        cycles = 0;
        while (cyc < 300 && !done_seen) begin
            r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc > 5) : 1'($urandom_range(0, 1));
            str_ready = r;
            #1;
            if (str_done) begin
                done_seen = 1'b1; got_err = str_err; cycles = cyc;
            end else begin
                chk("str_busy", 32'(str_busy), 32'h1);
                if (str_valid) begin
                    vcnt++;
                    if (pending) chk("str_hold", 32'(str_char), 32'(held));
                    if (r) begin got_q.push_back(str_char); pending = 1'b0; end
                    else begin pending = 1'b1; held = str_char; end
                end
            end
            if (poke && cyc == 2) begin str_start = 1'b1; str_addr = BASE; end
            else str_start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        str_start = 1'b0; str_ready = 1'b0;
        if (!done_seen) chk("str_timeout", 32'h0, 32'h1);
        chk("str_len", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("str_char", 32'(got_q[i]), 32'(exp_q[i]));
        chk("str_err", 32'(got_err), 32'(exp_err));
        #1;
        chk("str_done_pulse", 32'(str_done), 32'h0);
        chk("str_idle", 32'(str_busy), 32'h0);
    endtask

    initial begin
        int cyc, vc, len, wait_n;
        logic [31:0] a;
        reset = 1'b1; mem_write = 1'b0; mem_read = 1'b0; size = 2'b00; load_signed = 1'b0;
        address = 32'h0; write_data = 32'h0; str_start = 1'b0; str_addr = 32'h0; str_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_busy", 32'(str_busy), 32'h0);
        chk("rst_valid", 32'(str_valid), 32'h0);
        chk("rst_done", 32'(str_done), 32'h0);
        chk("rst_err", 32'(str_err), 32'h0);
        chk("rst_char", 32'(str_char), 32'h0);
        chk("rst_rdata", read_data, 32'h0);
        chk("rst_fault", 32'(addr_fault), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) do_store(BASE + 32'(4 * i), 2'b10, $urandom);

        do_store(32'h7fff_fffc, 2'b10, 32'hdead_beef);
        load_const("lw_top", 32'h7fff_fffc, 2'b10, 1'b0, 32'hdead_beef, 1'b0);
        load_const("lb_sign", 32'h7fff_ffff, 2'b00, 1'b1, 32'hffff_ffde, 1'b0);
        do_store(32'h7fff_fff8, 2'b10, 32'h0);
        do_store(32'h7fff_fff9, 2'b00, 32'h0000_0041);
        load_const("lw_sb", 32'h7fff_fff8, 2'b10, 1'b0, 32'h0000_4100, 1'b0);
        load_const("lhu_sb", 32'h7fff_fffa, 2'b01, 1'b0, 32'h0000_0000, 1'b0);
        load_const("lw_misal", 32'h7fff_fffe, 2'b10, 1'b0, 32'h0, 1'b1);
        do_store(32'h7fff_fffd, 2'b10, 32'h1234_5678);
        load_const("lw_unchg", 32'h7fff_fffc, 2'b10, 1'b0, 32'hdead_beef, 1'b0);
        load_const("lw_below", BASE - 32'd4, 2'b10, 1'b0, 32'h0, 1'b1);
        load_const("lh_rsvd", BASE, 2'b11, 1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            a = pick_addr();
            if ($urandom_range(0, 1) == 0) do_store(a, 2'($urandom_range(0, 3)), $urandom);
            else do_load(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        do_store(32'h7fff_fff0, 2'b10, 32'h0000_6948);
        run_string(32'h7fff_fff0, 0, 1'b0, cyc, vc);
        chk("hi_cycles", 32'(cyc), 32'd6);
        chk("hi_valid_cycles", 32'(vc), 32'd2);
        run_string(32'h7fff_fff0, 1, 1'b0, cyc, vc);
        chk("hi_stall_valid", 32'(vc), 32'd6);

        // Reset while a character is being offered.
        @(negedge clk);
        str_addr = 32'h7fff_fff0; str_start = 1'b1; str_ready = 1'b0;
        @(negedge clk);
        str_start = 1'b0;
        wait_n = 0;
        while (!str_valid && wait_n < 10) begin @(negedge clk); wait_n++; end
        chk("rst_mid_reach_out", 32'(str_valid), 32'h1);
        reset = 1'b1;
        @(negedge clk); #1;
        chk("rmid_valid", 32'(str_valid), 32'h0);
        chk("rmid_busy", 32'(str_busy), 32'h0);
        chk("rmid_done", 32'(str_done), 32'h0);
        chk("rmid_err", 32'(str_err), 32'h0);
        chk("rmid_char", 32'(str_char), 32'h0);
        reset = 1'b0;
        run_string(32'h7fff_fff0, 0, 1'b0, cyc, vc);

        do_store(TOP, 2'b10, 32'h4142_4344);
        run_string(TOP + 32'd1, 0, 1'b0, cyc, vc);
        for (int i = 0; i < 20; i++) do_store(BASE + 32'd64 + 32'(i), 2'b00, 32'h61 + 32'(i));
        do_store(BASE + 32'd84, 2'b00, 32'h0);
        run_string(BASE + 32'd64, 2, 1'b0, cyc, vc);
        run_string(BASE + 32'd68, 0, 1'b0, cyc, vc);

        for (int t = 0; t < 20; t++) begin
            a = BASE + 32'($urandom_range(0, 4*DEPTH - 1));
            len = $urandom_range(0, 20);
            for (int i = 0; i < len; i++)
                if (!ref_fault(a + 32'(i), 2'b00)) do_store(a + 32'(i), 2'b00, 32'($urandom_range(1, 255)));
            if (!ref_fault(a + 32'(len), 2'b00)) do_store(a + 32'(len), 2'b00, 32'h0);
            run_string(a, 2, (t == 3), cyc, vc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
